// File: rtl/taiko_pkg.sv
// Shared constants and helpers for the drum-game blocks: judgment
// encodings, score values, screen geometry and hit-marker defaults.
package taiko_pkg;

  // Judgment code as seen by the score/combo display.
  typedef enum logic [1:0] {
    JUDGE_NONE  = 2'b00,
    JUDGE_MISS  = 2'b01,
    JUDGE_GOOD  = 2'b10,
    JUDGE_GREAT = 2'b11
  } judgment_e;

  // Judge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_JUDGED = 2'd2
  } judge_state_e;

  // Score awarded per judgment and the combo level that doubles it.
  localparam logic [15:0] SCORE_GREAT     = 16'd300;
  localparam logic [15:0] SCORE_GOOD      = 16'd100;
  localparam logic [7:0]  BONUS_THRESHOLD = 8'd10;

  // Screen geometry: notes enter at the right edge.
  localparam int unsigned SCREEN_W = 32'd160;

  // Hit marker position and window half-widths, in pixels.
  localparam int unsigned HIT_X_DEF     = 32'd16;
  localparam int unsigned GREAT_WIN_DEF = 32'd2;
  localparam int unsigned GOOD_WIN_DEF  = 32'd6;

  // 16-bit add that clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Distance between two 8-bit coordinates, widened so it never underflows.
  function automatic logic [8:0] abs_diff9(input logic [7:0] a,
                                           input logic [7:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Bundle between the note mover / key inputs and the hit judge, plus the
// judgment and score signals going to the display.
interface hit_judge_if;

  logic        note_spawn;
  logic        note_valid;
  logic [7:0]  note_x;
  logic        note_kind;
  logic        key_don;
  logic        key_ka;
  logic        judge_valid;
  logic [1:0]  judgment;
  logic        on_hit;
  logic [15:0] score;
  logic [7:0]  combo;

  // Side that drives the note stream and keys and watches the results.
  modport master (
    output note_spawn, note_valid, note_x, note_kind, key_don, key_ka,
    input  judge_valid, judgment, on_hit, score, combo
  );

  // The judge itself.
  modport slave (
    input  note_spawn, note_valid, note_x, note_kind, key_don, key_ka,
    output judge_valid, judgment, on_hit, score, combo
  );

endinterface

// File: rtl/key_edge_sync.sv
// Brings one raw asynchronous key into the clock domain through two flops
// and produces a single-cycle pulse on each rising edge of the key.
module key_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic key,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-stage synchronizer followed by a one-cycle history flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // High only in the first cycle the synchronized key is seen high.
  assign press = sync2_r & ~prev_r;

endmodule

// File: rtl/hit_judge.sv
// Drum hit judge: compares key presses with the position of the note that
// is currently on screen and emits one GREAT/GOOD/MISS judgment per note,
// keeping a saturating score and combo.
// Optional feature macro: HIT_JUDGE_COMBO_BONUS_EN -- when defined, a combo
// of 10 or more before the update doubles the points for GREAT and GOOD.
module hit_judge
  import taiko_pkg::*;
#(
  parameter int unsigned HIT_X     = HIT_X_DEF,
  parameter int unsigned GREAT_WIN = GREAT_WIN_DEF,
  parameter int unsigned GOOD_WIN  = GOOD_WIN_DEF
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  hit_judge_if.slave  bus
);

  localparam logic [7:0] HIT_X_8     = 8'(HIT_X);
  localparam logic [8:0] HIT_X_9     = 9'(HIT_X);
  localparam logic [8:0] GREAT_WIN_9 = 9'(GREAT_WIN);
  localparam logic [8:0] GOOD_WIN_9  = 9'(GOOD_WIN);

  // Synchronized key edges.
  logic press_don_s;
  logic press_ka_s;

  key_edge_sync u_sync_don (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .key    (bus.key_don),
    .press  (press_don_s)
  );

  key_edge_sync u_sync_ka (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .key    (bus.key_ka),
    .press  (press_ka_s)
  );

  // Window geometry of the current note.
  logic [8:0] dist_s;
  logic       in_great_s;
  logic       in_good_s;
  logic       late_s;
  logic       single_press_s;
  logic       match_s;

  assign dist_s     = abs_diff9(bus.note_x, HIT_X_8);
  assign in_great_s = (dist_s <= GREAT_WIN_9);
  assign in_good_s  = (dist_s <= GOOD_WIN_9);
  // Note has scrolled past the far edge of the GOOD window.
  assign late_s     = (({1'b0, bus.note_x} + GOOD_WIN_9) < HIT_X_9);
  // Both keys in the same cycle count as no press at all.
  assign single_press_s = press_don_s ^ press_ka_s;
  assign match_s = (press_don_s & ~bus.note_kind) | (press_ka_s & bus.note_kind);

  judge_state_e state_r;
  judge_state_e state_nx_s;
  logic         judge_s;
  judgment_e    verdict_s;

  // Judge FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and the judgment to issue this cycle, if any.
  always_comb begin
    state_nx_s = state_r;
    judge_s    = 1'b0;
    verdict_s  = JUDGE_NONE;
    case (state_r)
      ST_IDLE: begin
        if (bus.note_spawn) begin
          state_nx_s = ST_ARMED;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (bus.note_spawn) begin
          // New note replaces an unjudged one; any press this cycle is dropped.
          judge_s    = 1'b1;
          verdict_s  = JUDGE_MISS;
          state_nx_s = ST_ARMED;
        end else if (!bus.note_valid || late_s) begin
          judge_s    = 1'b1;
          verdict_s  = JUDGE_MISS;
          state_nx_s = ST_JUDGED;
        end else if (single_press_s && in_good_s) begin
          judge_s    = 1'b1;
          state_nx_s = ST_JUDGED;
          if (!match_s) begin
            verdict_s = JUDGE_MISS;
          end else if (in_great_s) begin
            verdict_s = JUDGE_GREAT;
          end else begin
            verdict_s = JUDGE_GOOD;
          end
        end else begin
          state_nx_s = ST_ARMED;
        end
      end
      ST_JUDGED: begin
        if (bus.note_spawn) begin
          state_nx_s = ST_ARMED;
        end else if (!bus.note_valid) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_JUDGED;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  logic        judge_valid_r;
  judgment_e   judgment_r;
  logic        on_hit_r;
  logic [15:0] score_r;
  logic [7:0]  combo_r;

  logic [15:0] base_add_s;
  logic [15:0] add_s;
  logic [15:0] score_nx_s;
  logic [7:0]  combo_nx_s;
  logic        is_hit_s;

  // Points for the verdict and the resulting score/combo values.
  always_comb begin
    base_add_s = 16'd0;
    is_hit_s   = 1'b0;
    case (verdict_s)
      JUDGE_GREAT: begin
        base_add_s = SCORE_GREAT;
        is_hit_s   = 1'b1;
      end
      JUDGE_GOOD: begin
        base_add_s = SCORE_GOOD;
        is_hit_s   = 1'b1;
      end
      default: begin
        base_add_s = 16'd0;
        is_hit_s   = 1'b0;
      end
    endcase
`ifdef HIT_JUDGE_COMBO_BONUS_EN
    // Bonus is decided on the combo value before this judgment counts.
    add_s = (combo_r >= BONUS_THRESHOLD) ? {base_add_s[14:0], 1'b0} : base_add_s;
`else
    add_s = base_add_s;
`endif
    score_nx_s = sat_add16(score_r, add_s);
    if (!is_hit_s) begin
      combo_nx_s = 8'd0;
    end else if (combo_r == 8'hFF) begin
      combo_nx_s = 8'hFF;
    end else begin
      combo_nx_s = combo_r + 8'd1;
    end
  end

  // Registered judgment strobe, held judgment code, score and combo.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      judge_valid_r <= 1'b0;
      judgment_r    <= JUDGE_NONE;
      on_hit_r      <= 1'b0;
      score_r       <= 16'd0;
      combo_r       <= 8'd0;
    end else begin
      judge_valid_r <= judge_s;
      on_hit_r      <= judge_s & is_hit_s;
      if (judge_s) begin
        judgment_r <= verdict_s;
        score_r    <= score_nx_s;
        combo_r    <= combo_nx_s;
      end else begin
        judgment_r <= judgment_r;
        score_r    <= score_r;
        combo_r    <= combo_r;
      end
    end
  end

  assign bus.judge_valid = judge_valid_r;
  assign bus.judgment    = judgment_r;
  assign bus.on_hit      = on_hit_r;
  assign bus.score       = score_r;
  assign bus.combo       = combo_r;

endmodule
